// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   PS/2 keyboard receiver: debounced clock edge detection, 11-bit frame
//   reception with odd parity and stop-bit checks, E0/F0 prefix folding into
//   per-event flags, and a DEPTH-entry event FIFO with valid/ready handshake.
//
//   Optional feature: define PS2_RX_TIMEOUT_EN to build a stalled-frame
//   watchdog that aborts a frame after TIMEOUT_CYCLES idle clk cycles.
//   Without it, err_timeout is tied to 0.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   ps2_clk      raw PS/2 clock pin (asynchronous)
//   ps2_data     raw PS/2 data pin (asynchronous)
//   ev_code      scan code of the FIFO head event
//   ev_ext       head event was preceded by E0
//   ev_rel       head event was preceded by F0 (release)
//   ev_valid     FIFO holds at least one event
//   ev_ready     consumer accepts the head event
//   count        FIFO occupancy
//   overflow     1-cycle pulse: event dropped because FIFO was full
//   err_parity   1-cycle pulse: frame parity failure
//   err_frame    1-cycle pulse: stop bit was 0
//   err_timeout  1-cycle pulse: frame aborted by the watchdog
module ps2_rx_fifo #(
  parameter int DEB_LEN        = 8,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  output logic [7:0]               ev_code,
  output logic                     ev_ext,
  output logic                     ev_rel,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     err_parity,
  output logic                     err_frame,
  output logic                     err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // ---------------------------------------------------------------------
  // Synchronisers and clock debounce
  // ---------------------------------------------------------------------
  logic             data_s1, data_s2;
  logic             clk_s1, clk_s2;
  logic [DEB_LEN:0] hist;
  logic             bitclk;
  logic             bitedge;

  // Lines idle high, so everything resets to 1 and no edge appears on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      hist    <= '1;
      bitclk  <= 1'b1;
    end else begin
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      hist    <= {hist[DEB_LEN-1:0], clk_s2};
      if (&hist)
        bitclk <= 1'b1;
      else if (hist == '0)
        bitclk <= 1'b0;
    end
  end

  // The oldest history bit still being 1 marks the first cycle in which the
  // low DEB_LEN bits are all 0; the next cycle the whole history is 0 and
  // bitclk drops, so the edge strobe is exactly one cycle wide.
  assign bitedge = bitclk && hist[DEB_LEN] && (hist[DEB_LEN-1:0] == '0);

  // ---------------------------------------------------------------------
  // Frame receiver and prefix decoder
  // ---------------------------------------------------------------------
  logic [3:0] bitcnt;
  logic [7:0] shreg;
  logic       par_acc;
  logic       pend_ext, pend_rel;
  logic       stop_edge, frame_bad, parity_bad, byte_ok;
  logic       is_e0, is_f0, push;
  logic       wd_expire;

  assign stop_edge  = bitedge && (bitcnt == 4'd10);
  assign frame_bad  = stop_edge && !data_s2;
  assign parity_bad = stop_edge && data_s2 && !par_acc;
  assign byte_ok    = stop_edge && data_s2 && par_acc;
  assign is_e0      = (shreg == 8'hE0);
  assign is_f0      = (shreg == 8'hF0);
  assign push       = byte_ok && !is_e0 && !is_f0;

  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt     <= 4'd0;
      shreg      <= 8'h00;
      par_acc    <= 1'b0;
      pend_ext   <= 1'b0;
      pend_rel   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      err_parity <= parity_bad;
      err_frame  <= frame_bad;
      if (bitedge) begin
        if (bitcnt == 4'd0) begin
          // Only a low start bit opens a frame.
          if (!data_s2) begin
            bitcnt  <= 4'd1;
            par_acc <= 1'b0;
          end
        end else if (bitcnt <= 4'd9) begin
          par_acc <= par_acc ^ data_s2;
          if (bitcnt <= 4'd8)
            shreg <= {data_s2, shreg[7:1]};
          bitcnt <= bitcnt + 4'd1;
        end else begin
          bitcnt <= 4'd0;
          if (!data_s2 || !par_acc) begin
            pend_ext <= 1'b0;
            pend_rel <= 1'b0;
          end else if (is_e0) begin
            pend_ext <= 1'b1;
          end else if (is_f0) begin
            pend_rel <= 1'b1;
          end else begin
            // Flags clear even when the event is dropped on overflow.
            pend_ext <= 1'b0;
            pend_rel <= 1'b0;
          end
        end
      end else if (wd_expire) begin
        bitcnt   <= 4'd0;
        pend_ext <= 1'b0;
        pend_rel <= 1'b0;
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  // ---------------------------------------------------------------------
  // Stalled-frame watchdog
  // ---------------------------------------------------------------------
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;

  assign wd_expire = (bitcnt != 4'd0) && !bitedge &&
                     (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= wd_expire;
      if (bitedge || wd_expire || bitcnt == 4'd0)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WDW'(1);
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Event FIFO: entry = {ext, rel, code}
  // ---------------------------------------------------------------------
  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, wr;
  logic [9:0]    head;

  assign ev_valid = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign pop      = ev_valid && ev_ready;
  // When full, a push is only taken if a pop frees the slot in the same cycle.
  assign wr       = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= {pend_ext, pend_rel, shreg};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head read is asynchronous so the entry is visible the cycle ev_valid
  // rises; outputs are forced to 0 while empty to keep them clean.
  assign head    = mem[rd_ptr];
  assign ev_code = ev_valid ? head[7:0] : 8'h00;
  assign ev_ext  = ev_valid ? head[9]   : 1'b0;
  assign ev_rel  = ev_valid ? head[8]   : 1'b0;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo
//   Directed bench for ps2_rx_fifo. A queue-based model predicts FIFO
//   contents, occupancy and error/overflow pulses from the frame-level
//   rules; a negedge compare process checks the DUT every cycle, and the
//   stimulus sequence adds hand-computed literal expectations.
module tb_ps2_rx_fifo;

  localparam int DEB_LEN = 4;
  localparam int DEPTH   = 4;
  localparam int TO      = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext, ev_rel, ev_valid;
  logic [$clog2(DEPTH):0] count;
  logic       overflow, err_parity, err_frame, err_timeout;

  ps2_rx_fifo #(.DEB_LEN(DEB_LEN), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_rel(ev_rel), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .count(count), .overflow(overflow),
    .err_parity(err_parity), .err_frame(err_frame), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_fall = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  logic [9:0] mq[$];
  bit m_ext = 0, m_rel = 0;
  bit exp_par = 0, exp_frm = 0, exp_ovf = 0;
  bit to_window = 0;
  int to_seen = 0, par_seen = 0, frm_seen = 0, ovf_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outcome of a completed frame, applied at the moment the stop bit is taken.
  task automatic model_stop(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    if (!stop_ok) begin
      exp_frm = 1; m_ext = 0; m_rel = 0;
    end else if (!par_ok) begin
      exp_par = 1; m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else begin
      if (mq.size() >= DEPTH) exp_ovf = 1;
      else mq.push_back({m_ext, m_rel, b});
      m_ext = 0; m_rel = 0;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
      chk("err_parity", 32'(err_parity), 32'(exp_par));
      chk("err_frame", 32'(err_frame), 32'(exp_frm));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      if (!to_window) chk("err_timeout", 32'(err_timeout), 32'd0);
      else if (err_timeout) to_seen++;
      if (err_parity) par_seen++;
      if (err_frame) frm_seen++;
      if (overflow) ovf_seen++;
      if (ev_valid && ev_ready) begin
        if (mq.size() == 0) chk("pop_model_empty", 32'd1, 32'd0);
        else begin
          chk("pop_entry", {22'd0, ev_ext, ev_rel, ev_code}, {22'd0, mq[0]});
          void'(mq.pop_front());
        end
      end
      exp_par = 0; exp_frm = 0; exp_ovf = 0;
    end
  end

  // ---------------- PS/2 driving ----------------
  // Fall is driven 1 time unit after a posedge; the task returns one time
  // unit after the posedge that acts on the resulting bit edge.
  task automatic ps2_fall(input logic d, input bit rdy_pulse);
    ps2_data = d;
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (DEB_LEN + 2) @(posedge clk);
    #1 if (rdy_pulse) ev_ready = 1'b1;
    @(posedge clk);
    #1 if (rdy_pulse) ev_ready = 1'b0;
  endtask

  task automatic ps2_rise();
    repeat (10) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic ps2_bit(input logic d);
    ps2_fall(d, 1'b0);
    ps2_rise();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                            input bit rdy_pulse);
    logic par;
    par = (~^b) ^ !par_ok;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_fall(stop_ok, rdy_pulse);
    model_stop(b, par_ok, stop_ok);
    ps2_rise();
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [9:0] exp);
    chk(name, {22'd0, ev_ext, ev_rel, ev_code}, {22'd0, exp});
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    @(posedge clk);
    #1 ev_ready = 1'b0;
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    for (int i = 0; i < DEPTH + 4 && mq.size() != 0; i++) @(posedge clk);
    #1 ev_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [9:0] exp_list [4];
    int delta;
    exp_list[0] = 10'h002; exp_list[1] = 10'h003;
    exp_list[2] = 10'h004; exp_list[3] = 10'h006;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_outputs", {24'd0, ev_valid, overflow, err_parity, err_frame, err_timeout, ev_ext, ev_rel, 1'b0},
        32'd0);
    chk("rst_code", 32'(ev_code), 32'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // Plain make code
    send_frame(8'h1C, 1, 1, 0);
    chk_head("head_1C", 10'h01C);
    chk("count_1C", 32'(count), 32'd1);
    drain();

    // Extended release, then plain
    send_frame(8'hE0, 1, 1, 0);
    send_frame(8'hF0, 1, 1, 0);
    chk("prefix_no_event", 32'(count), 32'd0);
    send_frame(8'h75, 1, 1, 0);
    chk_head("head_E0F075", 10'h375);
    chk("count_E0F075", 32'(count), 32'd1);
    send_frame(8'h75, 1, 1, 0);
    chk("count_two", 32'(count), 32'd2);
    pop_one();
    chk_head("head_75_plain", 10'h075);
    drain();

    // Errors
    send_frame(8'h1C, 0, 1, 0);
    chk("par_pulses", 32'(par_seen), 32'd1);
    chk("par_no_push", 32'(count), 32'd0);
    send_frame(8'h1C, 0, 0, 0);
    chk("frm_pulses", 32'(frm_seen), 32'd1);
    chk("par_pulses_after_frm", 32'(par_seen), 32'd1);
    send_frame(8'hF0, 1, 1, 0);
    send_frame(8'h1C, 1, 1, 0);
    chk_head("head_F01C", 10'h11C);
    drain();
    send_frame(8'hF0, 1, 1, 0);
    send_frame(8'h33, 0, 1, 0);
    send_frame(8'h1C, 1, 1, 0);
    chk_head("head_flags_cleared", 10'h01C);
    drain();

    // Overflow with DEPTH=4
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 1, 0);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_pulses", 32'(ovf_seen), 32'd1);
    chk_head("ovf_head", 10'h001);

    // Full FIFO: pop coincides with the push -> accepted, no overflow
    send_frame(8'h06, 1, 1, 1);
    chk("full_pushpop_count", 32'(count), 32'd4);
    chk("full_pushpop_no_ovf", 32'(ovf_seen), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk_head("drain_order", exp_list[i]);
      pop_one();
    end
    #1 chk("drained", 32'(count), 32'd0);

    // Reset in the middle of a frame with a non-empty FIFO
    send_frame(8'h1C, 1, 1, 0);
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    ps2_data = 1'b1;
    reset = 1'b1;
    mq.delete(); m_ext = 0; m_rel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_outputs", {24'd0, ev_valid, overflow, err_parity, err_frame, err_timeout, ev_ext, ev_rel, 1'b0},
        32'd0);
    chk("midrst_code", 32'(ev_code), 32'd0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send_frame(8'h1C, 1, 1, 0);
    chk_head("after_rst_head", 10'h01C);
    chk("after_rst_count", 32'(count), 32'd1);
    drain();

`ifdef PS2_RX_TIMEOUT_EN
    // Stalled frame: start + 3 data bits, then the clock stays high
    to_window = 1;
    to_seen = 0;
    ps2_bit(1'b0);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    for (int k = 0; k < TO + 400 && !err_timeout; k++) @(negedge clk);
    delta = cyc - last_fall;
    chk("timeout_latency_ok", 32'(delta >= TO && delta <= TO + 20), 32'd1);
    repeat (5) @(posedge clk);
    #1 to_window = 0;
    chk("timeout_pulses", 32'(to_seen), 32'd1);
    send_frame(8'h1C, 1, 1, 0);
    chk_head("after_timeout_head", 10'h01C);
    drain();
`endif

    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
